speed_select: RTL

Upstream control stage for the four-rate toggle divider. Debounces two raw push-buttons (faster / slower) and maintains the 2-bit `control` speed code that drives the divider's step-size select. Exactly one speed step is applied per clean button press. The code saturates at 0 (slowest) and 3 (fastest).

---
 rtl/speed_select_if.sv | 12 +
 rtl/speed_select.sv | 88 ++++++++
 2 files changed

// File: rtl/speed_select_if.sv
// Button inputs and speed-code outputs shared between speed_select and its driver/consumer.
interface speed_select_if;
    logic       btn_up;
    logic       btn_down;
    logic [1:0] control;
    logic       changed;
    logic       at_max;
    logic       at_min;

    modport master (output btn_up, btn_down, input control, changed, at_max, at_min);
    modport slave  (input btn_up, btn_down, output control, changed, at_max, at_min);
endinterface

// File: rtl/speed_select.sv
// Debounced up/down buttons stepping a saturating 2-bit speed code; press-to-control latency is
// DEBOUNCE_CYCLES+4 cycles. No backpressure: every clean press is applied.
module speed_select #(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [1:0] RESET_SPEED     = 2'b00
) (
    input logic          clk,
    input logic          reset,
    speed_select_if.slave bus
);
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is the "faster" path, bit 1 the "slower" path.
    logic [1:0]  raw;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [1:0]  stable;
    logic [1:0]  stable_d;
    logic [1:0]  ev;
    logic [15:0] cnt [2];

    logic [1:0]  control_q;
    logic [1:0]  control_nxt;
    logic        changed_q;
    logic        changed_nxt;
    logic        up_ev;
    logic        dn_ev;

    assign raw = {bus.btn_down, bus.btn_up};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_d <= '0;
            ev       <= '0;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            stable_d <= stable;
            // Rising edge of the debounced level only; releases and holds give nothing.
            ev       <= stable & ~stable_d;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    assign up_ev = ev[0];
    assign dn_ev = ev[1];

    always_comb begin
        control_nxt = control_q;
        changed_nxt = 1'b0;
        if (up_ev && !dn_ev && control_q != 2'd3) begin
            control_nxt = control_q + 2'd1;
            changed_nxt = 1'b1;
        end else if (dn_ev && !up_ev && control_q != 2'd0) begin
            control_nxt = control_q - 2'd1;
            changed_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            control_q <= RESET_SPEED;
            changed_q <= 1'b0;
        end else begin
            control_q <= control_nxt;
            changed_q <= changed_nxt;
        end
    end

    assign bus.control = control_q;
    assign bus.changed = changed_q;
    assign bus.at_max  = (control_q == 2'd3);
    assign bus.at_min  = (control_q == 2'd0);
endmodule
